// File: rtl/router_reg_if.sv
// FSM strobe, source byte and FIFO write-bus bundle for the router register stage.
// master = FSM/source side, slave = router_reg.
interface router_reg_if #(
  parameter int WIDTH = 8
);
  logic             pkt_valid;
  logic [WIDTH-1:0] data_in;
  logic             fifo_full;
  logic             detect_add;
  logic             lfd_state;
  logic             ld_state;
  logic             laf_state;
  logic             full_state;
  logic             rst_int_reg;
  logic [WIDTH-1:0] dout;
  logic             parity_done;
  logic             low_pkt_valid;
  logic             err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath register: header latch, FIFO write byte, parked byte, running parity check.
// Latency: one cycle from any FSM strobe to its registered effect on every output.
// Backpressure: a byte seen with fifo_full is parked in hold and replayed in LOAD_AFTER_FULL.
module router_reg #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         resetn,
  router_reg_if.slave bus
);

  logic [WIDTH-1:0] hdr;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] int_par;
  logic [WIDTH-1:0] pkt_par;
  logic [WIDTH-1:0] dout_q;
  logic             parity_done_q;
  logic             low_pkt_valid_q;
  logic             err_q;
  logic             any_strobe;

  assign any_strobe = bus.detect_add | bus.lfd_state | bus.ld_state |
                      bus.laf_state  | bus.full_state | bus.rst_int_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hdr             <= '0;
      hold            <= '0;
      int_par         <= '0;
      pkt_par         <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      if (bus.detect_add) begin
        if (bus.pkt_valid) hdr <= bus.data_in;
        int_par       <= '0;
        parity_done_q <= 1'b0;
        err_q         <= 1'b0;
      end else if (bus.lfd_state) begin
        dout_q  <= hdr;
        int_par <= int_par ^ hdr;
      end else if (bus.ld_state) begin
        if (bus.pkt_valid) begin
          // Payload is folded once here, even when parked, so LAF never refolds it.
          int_par <= int_par ^ bus.data_in;
          if (bus.fifo_full) hold   <= bus.data_in;
          else               dout_q <= bus.data_in;
        end else if (bus.fifo_full) begin
          hold <= bus.data_in;
        end else begin
          dout_q        <= bus.data_in;
          pkt_par       <= bus.data_in;
          parity_done_q <= 1'b1;
        end
      end else if (bus.laf_state) begin
        dout_q <= hold;
        // A parked parity byte is recognised by pkt_valid having already dropped.
        if (low_pkt_valid_q && !parity_done_q) begin
          pkt_par       <= hold;
          parity_done_q <= 1'b1;
        end
      end

      if (bus.rst_int_reg)
        low_pkt_valid_q <= 1'b0;
      else if (bus.ld_state && !bus.pkt_valid)
        low_pkt_valid_q <= 1'b1;

      if (!bus.detect_add && any_strobe && parity_done_q)
        err_q <= (int_par != pkt_par);
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: hand-written packets with literal expectations, then random packets
// checked against a packet-level model (bytes written, xor of header+payload vs parity byte).
module tb_router_reg;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b000001;
  localparam logic [5:0] S_LFD  = 6'b000010;
  localparam logic [5:0] S_LD   = 6'b000100;
  localparam logic [5:0] S_LAF  = 6'b001000;
  localparam logic [5:0] S_FFS  = 6'b010000;
  localparam logic [5:0] S_CPE  = 6'b100000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  router_reg_if #(.WIDTH(8)) bus ();

  router_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model state: what the outputs must be after the upcoming edge.
  logic [7:0] m_dout;
  logic       m_pd, m_lpv, m_err;
  logic [7:0] exp_dout;
  logic       exp_pd, exp_lpv, exp_err;
  logic       chk_en = 1'b0;

  logic [7:0] pay [0:63];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("dout",          bus.dout,                 exp_dout);
      chk("parity_done",   {7'd0, bus.parity_done},   {7'd0, exp_pd});
      chk("low_pkt_valid", {7'd0, bus.low_pkt_valid}, {7'd0, exp_lpv});
      chk("err",           {7'd0, bus.err},           {7'd0, exp_err});
    end
  end

  task automatic step(input logic rn, input logic [5:0] s, input logic pv,
                      input logic full, input logic [7:0] d);
    @(negedge clk);
    resetn          = rn;
    bus.detect_add  = s[0];
    bus.lfd_state   = s[1];
    bus.ld_state    = s[2];
    bus.laf_state   = s[3];
    bus.full_state  = s[4];
    bus.rst_int_reg = s[5];
    bus.pkt_valid   = pv;
    bus.fifo_full   = full;
    bus.data_in     = d;
    exp_dout = m_dout;
    exp_pd   = m_pd;
    exp_lpv  = m_lpv;
    exp_err  = m_err;
    chk_en   = 1'b1;
    @(posedge clk);
  endtask

  // Hand-computed expectation for the directed packets.
  task automatic ex(input logic [7:0] d, input logic pd, input logic lpv, input logic e);
    m_dout = d;
    m_pd   = pd;
    m_lpv  = lpv;
    m_err  = e;
  endtask

  function automatic logic [7:0] pkt_xor(input logic [7:0] h, input int n);
    logic [7:0] x;
    x = h;
    for (int i = 0; i < n; i++) x ^= pay[i];
    return x;
  endfunction

  // One packet through DA-LFD-LD..-CPE-idle; full_at picks the byte (n = parity) seen with fifo_full.
  task automatic run_pkt(input logic [7:0] h, input int n, input logic [7:0] par,
                         input int full_at, input int ffs_n);
    logic [7:0] b;
    logic       pvv;
    m_pd  = 1'b0;
    m_err = 1'b0;
    step(1'b1, S_DA, 1'b1, 1'b0, h);
    m_dout = h;
    step(1'b1, S_LFD, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i <= n; i++) begin
      pvv = (i < n);
      b   = pvv ? pay[i] : par;
      if (!pvv) m_lpv = 1'b1;
      if (i == full_at) begin
        step(1'b1, S_LD, pvv, 1'b1, b);
        for (int k = 0; k < ffs_n; k++) step(1'b1, S_FFS, pvv, 1'b1, 8'($urandom));
        m_dout = b;
        if (!pvv) m_pd = 1'b1;
        step(1'b1, S_LAF, pvv, 1'b0, 8'($urandom));
      end else begin
        m_dout = b;
        if (!pvv) m_pd = 1'b1;
        step(1'b1, S_LD, pvv, 1'b0, b);
      end
    end
    m_lpv = 1'b0;
    m_err = (pkt_xor(h, n) != par);
    step(1'b1, S_CPE, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, S_IDLE, 1'b0, 1'($urandom), 8'($urandom));
  endtask

  initial begin
    int         n, r, full_at;
    logic [7:0] h, par;
    logic [5:0] len;
    logic [1:0] dest;

    resetn = 1'b0;
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state = 0; bus.rst_int_reg = 0; bus.pkt_valid = 0; bus.fifo_full = 0;
    bus.data_in = 8'h00;

    // Reset
    ex(8'h00, 0, 0, 0); step(1'b0, S_IDLE, 1'b0, 1'b0, 8'h5A);

    // Clean packet, dest 1, length 3
    ex(8'h00, 0, 0, 0); step(1'b1, S_DA,  1'b1, 1'b0, 8'h0D);
    ex(8'h0D, 0, 0, 0); step(1'b1, S_LFD, 1'b1, 1'b0, 8'h11);
    ex(8'h11, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h11);
    ex(8'h22, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h22);
    ex(8'h33, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h33);
    ex(8'h0D, 1, 1, 0); step(1'b1, S_LD,  1'b0, 1'b0, 8'h0D);
    ex(8'h0D, 1, 0, 0); step(1'b1, S_CPE, 1'b0, 1'b0, 8'h00);

    // Corrupt parity, err clears one cycle after the next DA
    ex(8'h0D, 0, 0, 0); step(1'b1, S_DA,  1'b1, 1'b0, 8'h0D);
    ex(8'h0D, 0, 0, 0); step(1'b1, S_LFD, 1'b1, 1'b0, 8'h11);
    ex(8'h11, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h11);
    ex(8'h22, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h22);
    ex(8'h33, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h33);
    ex(8'h0E, 1, 1, 0); step(1'b1, S_LD,  1'b0, 1'b0, 8'h0E);
    ex(8'h0E, 1, 0, 1); step(1'b1, S_CPE, 1'b0, 1'b0, 8'h00);
    ex(8'h0E, 1, 0, 1); step(1'b1, S_IDLE, 1'b0, 1'b0, 8'hFF);

    // FIFO full mid-payload on 0x22
    ex(8'h0E, 0, 0, 0); step(1'b1, S_DA,  1'b1, 1'b0, 8'h0D);
    ex(8'h0D, 0, 0, 0); step(1'b1, S_LFD, 1'b1, 1'b0, 8'h11);
    ex(8'h11, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h11);
    ex(8'h11, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b1, 8'h22);
    ex(8'h11, 0, 0, 0); step(1'b1, S_FFS, 1'b1, 1'b1, 8'hAA);
    ex(8'h11, 0, 0, 0); step(1'b1, S_FFS, 1'b1, 1'b1, 8'hBB);
    ex(8'h22, 0, 0, 0); step(1'b1, S_LAF, 1'b1, 1'b0, 8'hCC);
    ex(8'h33, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h33);
    ex(8'h0D, 1, 1, 0); step(1'b1, S_LD,  1'b0, 1'b0, 8'h0D);
    ex(8'h0D, 1, 0, 0); step(1'b1, S_CPE, 1'b0, 1'b0, 8'h00);

    // FIFO full on the parity byte
    ex(8'h0D, 0, 0, 0); step(1'b1, S_DA,  1'b1, 1'b0, 8'h0D);
    ex(8'h0D, 0, 0, 0); step(1'b1, S_LFD, 1'b1, 1'b0, 8'h11);
    ex(8'h11, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h11);
    ex(8'h22, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h22);
    ex(8'h33, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h33);
    ex(8'h33, 0, 1, 0); step(1'b1, S_LD,  1'b0, 1'b1, 8'h0D);
    ex(8'h33, 0, 1, 0); step(1'b1, S_FFS, 1'b0, 1'b1, 8'h77);
    ex(8'h0D, 1, 1, 0); step(1'b1, S_LAF, 1'b0, 1'b0, 8'h66);
    ex(8'h0D, 1, 0, 0); step(1'b1, S_CPE, 1'b0, 1'b0, 8'h00);

    // Zero-length packet: parity equals header
    ex(8'h0D, 0, 0, 0); step(1'b1, S_DA,  1'b1, 1'b0, 8'h01);
    ex(8'h01, 0, 0, 0); step(1'b1, S_LFD, 1'b0, 1'b0, 8'h01);
    ex(8'h01, 1, 1, 0); step(1'b1, S_LD,  1'b0, 1'b0, 8'h01);
    ex(8'h01, 1, 0, 0); step(1'b1, S_CPE, 1'b0, 1'b0, 8'h00);

    // Reset mid-packet, then a clean packet
    ex(8'h01, 0, 0, 0); step(1'b1, S_DA,  1'b1, 1'b0, 8'h0D);
    ex(8'h0D, 0, 0, 0); step(1'b1, S_LFD, 1'b1, 1'b0, 8'h11);
    ex(8'h11, 0, 0, 0); step(1'b1, S_LD,  1'b1, 1'b0, 8'h11);
    ex(8'h00, 0, 0, 0); step(1'b0, S_LD,  1'b1, 1'b0, 8'h22);
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_pkt(8'h0D, 3, 8'h0D, -1, 0);

    // Randomised packets against the packet-level model
    for (int k = 0; k < 60; k++) begin
      n    = $urandom_range(0, 5);
      len  = 6'(n);
      dest = 2'($urandom_range(0, 2));
      h    = {len, dest};
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      par = pkt_xor(h, n);
      if ($urandom_range(0, 2) == 0) par = par ^ (8'h01 << $urandom_range(0, 7));
      r = $urandom_range(0, 2 * n + 2);
      full_at = (r <= n) ? r : -1;
      run_pkt(h, n, par, full_at, $urandom_range(1, 2));
    end

    @(negedge clk);
    chk_en = 1'b0;
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage of the 1x3 router, directly downstream of `router_fsm`. It consumes the FSM state strobes and:
- latches the header byte;
- forwards header and payload bytes to the FIFO write bus, one registered cycle after the FSM asks for them;
- parks a byte that arrives while the FIFO is full;
- computes running XOR parity and compares it with the packet's trailing parity byte.

It returns `parity_done` and `low_pkt_valid` to the FSM and flags `err` on a parity mismatch.

## Interface
- `WIDTH`, 8, data byte width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `resetn` input 1: reset, synchronous, active-low.
- `pkt_valid` input 1: source byte valid; falls on the parity byte.
- `data_in` input WIDTH: source byte. Header byte is `[7:2]` length and `[1:0]` destination.
- `fifo_full` input 1: selected FIFO full.
- `detect_add` input 1: FSM is in DECODE_ADDRESS.
- `lfd_state` input 1: FSM is in LOAD_FIRST_DATA.
- `ld_state` input 1: FSM is in LOAD_DATA.
- `laf_state` input 1: FSM is in LOAD_AFTER_FULL.
- `full_state` input 1: FSM is in FIFO_FULL_STATE.
- `rst_int_reg` input 1: FSM is in CHECK_PARITY_ERROR; clears `low_pkt_valid`.
- `dout` output WIDTH: byte presented to the FIFO write bus.
- `parity_done` output 1: parity byte has been captured.
- `low_pkt_valid` output 1: `pkt_valid` dropped while in LOAD_DATA.
- `err` output 1: internal parity differs from packet parity.

## Operation
Internal registers: `hdr`, `hold` (full-state byte), `int_par`, `pkt_par`, all WIDTH.

- **Reset (`resetn`=0 at an edge):** all internal registers and all outputs go to 0. Reset has priority over every rule below, mid-packet included.
- **Header:**
  - `detect_add && pkt_valid`: `hdr <= data_in`.
  - `lfd_state`: `dout <= hdr`.
- **Payload, `ld_state && pkt_valid`:**
  - `!fifo_full`: `dout <= data_in`.
  - `fifo_full`: `hold <= data_in` and `dout` holds.
- **Parity byte, `ld_state && !pkt_valid`:**
  - `!fifo_full`: `dout <= data_in`, `pkt_par <= data_in`, `parity_done <= 1`.
  - `fifo_full`: `hold <= data_in`.
- **Load after full, `laf_state`:**
  - `dout <= hold`.
  - If `low_pkt_valid && !parity_done`: `pkt_par <= hold`, `parity_done <= 1`.
- **`full_state`:** `data_in` is ignored; `dout` and `hold` hold.
- **Running parity `int_par`:**
  - `detect_add`: `int_par <= 0`.
  - `lfd_state`: `int_par ^= hdr`.
  - `ld_state && pkt_valid` (full or not): `int_par ^= data_in`.
  - The parity byte is never folded in, and a held byte is never folded in twice at `laf_state`.
- **`low_pkt_valid`:**
  - Set on `ld_state && !pkt_valid`.
  - Cleared on `rst_int_reg`; clear wins if both occur in the same cycle.
- **`parity_done`:** cleared on `detect_add`. The set rules above take precedence only outside DECODE_ADDRESS.
- **`err`:**
  - While `parity_done`==1: `err <= (int_par != pkt_par)`.
  - Cleared on `detect_add`.
  - Otherwise holds.
- **Precedence:** one FSM strobe is active per cycle. If none is active, every register holds.

## Timing
- All outputs are registered. A strobe at edge N produces its effect at N+1.
- Header path: byte sampled in DECODE_ADDRESS, driven on `dout` one cycle after `lfd_state` is sampled.
- Payload path: `data_in` to `dout` latency is 1 cycle.
- Full path: the byte sampled with `fifo_full`=1 appears on `dout` the cycle after `laf_state` is sampled.
- `parity_done` rises 1 cycle after the parity byte is sampled, and stays high until the next `detect_add`.
- `err` is valid 1 cycle after `parity_done` rises, i.e. 2 cycles after the parity byte. It holds through CHECK_PARITY_ERROR into the next DECODE_ADDRESS, then clears 1 cycle after `detect_add`.
- `low_pkt_valid` rises 1 cycle after `pkt_valid` is sampled low in LOAD_DATA.
- Boundary conditions:
  - Zero-length packet (header then parity): parity equals the header.
  - `fifo_full` on the parity byte: the byte is captured via `hold` in LOAD_AFTER_FULL.
  - Back-to-back packets: `detect_add` clears `int_par`, `parity_done` and `err` before the next header is folded in.

## Test plan
- **Reset:** drive `resetn`=0 for 1 edge with all inputs X-free → `dout`=0x00, `err`=0, `parity_done`=0, `low_pkt_valid`=0.
- **Clean packet, dest 1, length 3:**
  - Stimulus: header 0x0D, payload 0x11, 0x22, 0x33, parity 0x0D, strobe sequence DA-LFD-LD×4-CPE.
  - `dout` sequence: 0x0D, 0x11, 0x22, 0x33, 0x0D.
  - `parity_done`=1 one cycle after the parity byte; `err`=0.
- **Corrupt parity:** same packet with parity 0x0E → `err`=1 two cycles after the parity byte; `err` clears 1 cycle after the next `detect_add`.
- **FIFO full mid-payload:**
  - Stimulus: `fifo_full`=1 while 0x22 is on `data_in` in LD, then FFS for 2 cycles, then LAF.
  - Response: `dout` holds 0x11 through FFS, then shows 0x22 after LAF; final `err`=0.
- **FIFO full on parity byte:**
  - Stimulus: `fifo_full`=1 as `pkt_valid` falls with 0x0D on `data_in`, then FFS, then LAF.
  - Response: `low_pkt_valid`=1, `parity_done` rises after LAF, `err`=0.
  - `rst_int_reg` clears `low_pkt_valid`.
- **Reset mid-packet:** `resetn`=0 during LD after 0x11 → all outputs 0. A following clean packet gives correct `dout` and `err`=0.
